sort3_stream: RTL and testbench

SORT3_STREAM -- requirements
Module: sort3_stream

---
 rtl/sort3_stream.sv | 126 ++++++++++++
 tb/tb_sort3_stream.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort3_stream.sv
// Three-operand stable sorter with a valid/ready stream output.
// A triple is captured in IDLE, ordered in SORT, and emitted one element per handshake in EMIT.
module sort3_stream #(
    parameter int W       = 8,
    parameter bit DESCEND = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_src,
    output logic         out_last,
    output logic [1:0]   o_dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits for ready, and payload is held while valid=1 and ready=0.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_c;
    logic [1:0]   r_k;
    logic [W-1:0] r_val [3];
    logic [1:0]   r_src [3];

    logic         w_ab;
    logic         w_ac;
    logic         w_bc;
    logic [1:0]   w_rank_a;
    logic [1:0]   w_rank_b;
    logic [1:0]   w_rank_c;
    logic [W-1:0] w_val [3];
    logic [1:0]   w_src [3];

    // w_xy = 1 when x is emitted before y; "or equal" keeps the lower source first on ties.
    always_comb begin
        if (DESCEND) begin
            w_ab = (r_a >= r_b);
            w_ac = (r_a >= r_c);
            w_bc = (r_b >= r_c);
        end else begin
            w_ab = (r_a <= r_b);
            w_ac = (r_a <= r_c);
            w_bc = (r_b <= r_c);
        end
    end

    assign w_rank_a = {1'b0, ~w_ab} + {1'b0, ~w_ac};
    assign w_rank_b = {1'b0, w_ab} + {1'b0, ~w_bc};
    assign w_rank_c = {1'b0, w_ac} + {1'b0, w_bc};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_val[i] = '0;
            w_src[i] = 2'd0;
        end
        w_val[w_rank_a] = r_a;
        w_src[w_rank_a] = 2'd0;
        w_val[w_rank_b] = r_b;
        w_src[w_rank_b] = 2'd1;
        w_val[w_rank_c] = r_c;
        w_src[w_rank_c] = 2'd2;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = SORT;
            SORT:    w_next = EMIT;
            EMIT:    if (out_ready && (r_k == 2'd2)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= 2'd0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            for (int i = 0; i < 3; i++) begin
                r_val[i] <= '0;
                r_src[i] <= 2'd0;
            end
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && in_valid) begin
                r_a <= a;
                r_b <= b;
                r_c <= c;
            end
            if (r_state == SORT) begin
                r_k <= 2'd0;
                for (int i = 0; i < 3; i++) begin
                    r_val[i] <= w_val[i];
                    r_src[i] <= w_src[i];
                end
            end
            if ((r_state == EMIT) && out_ready) begin
                r_k <= (r_k == 2'd2) ? 2'd0 : r_k + 2'd1;
            end
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == EMIT);
    assign out_data    = r_val[r_k];
    assign out_src     = r_src[r_k];
    assign out_last    = out_valid && (r_k == 2'd2);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sort3_stream.sv
// Bench for sort3_stream: scenario tasks plus a cycle monitor that checks the stream
// against a queue of expected (last, src, data) entries pushed at each accepted triple.
module tb_sort3_stream;

    localparam int W  = 8;
    localparam int EW = W + 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_valid_d = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] c = '0;
    logic         out_ready = 1'b0;
    logic         out_ready_d = 1'b0;

    logic         in_ready, out_valid, out_last;
    logic [W-1:0] out_data;
    logic [1:0]   out_src, dbg_state;
    logic         in_ready_d, out_valid_d, out_last_d;
    logic [W-1:0] out_data_d;
    logic [1:0]   out_src_d, dbg_state_d;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_last = 0;
    bit mon_en = 1'b0;
    bit sorting = 1'b0;
    logic [EW-1:0] exp_q[$];

    always #5 clk = ~clk;

    sort3_stream #(.W(W), .DESCEND(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src), .out_last(out_last),
        .o_dbg_state(dbg_state)
    );

    sort3_stream #(.W(W), .DESCEND(1'b1)) dut_d (
        .clk(clk), .rst(rst), .in_valid(in_valid_d), .in_ready(in_ready_d),
        .a(a), .b(b), .c(c), .out_valid(out_valid_d), .out_ready(out_ready_d),
        .out_data(out_data_d), .out_src(out_src_d), .out_last(out_last_d),
        .o_dbg_state(dbg_state_d)
    );

    // Reference: insertion sort that only moves an element past a strictly
    // smaller (or larger, descending) neighbour, so ties keep source order.
    function automatic logic [EW-1:0] model_elem(input logic [W-1:0] x, input logic [W-1:0] y,
                                                 input logic [W-1:0] z, input bit desc, input int k);
        logic [W-1:0] v[3];
        logic [1:0]   s[3];
        logic [W-1:0] tv;
        logic [1:0]   ts;
        v[0] = x; v[1] = y; v[2] = z;
        s[0] = 2'd0; s[1] = 2'd1; s[2] = 2'd2;
        for (int i = 1; i < 3; i++) begin
            for (int j = i; j > 0; j--) begin
                if (desc ? (v[j] > v[j-1]) : (v[j] < v[j-1])) begin
                    tv = v[j]; v[j] = v[j-1]; v[j-1] = tv;
                    ts = s[j]; s[j] = s[j-1]; s[j-1] = ts;
                end
            end
        end
        return {(k == 2), s[k], v[k]};
    endfunction

    always @(negedge clk) begin
        logic exp_v;
        if (mon_en) begin
            exp_v = (exp_q.size() != 0) && !sorting;
            n_cmp++;
            if (out_valid !== exp_v) begin
                n_err++;
                $display("FAIL mon_out_valid t=%0t got=%b exp=%b", $time, out_valid, exp_v);
            end
            n_cmp++;
            if (in_ready !== (exp_q.size() == 0)) begin
                n_err++;
                $display("FAIL mon_in_ready t=%0t got=%b exp=%b", $time, in_ready, exp_q.size() == 0);
            end
            if (out_valid && exp_v) begin
                n_cmp++;
                if ({out_last, out_src, out_data} !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL mon_element t=%0t got=%h/%0d/%b exp=%h/%0d/%b", $time,
                             out_data, out_src, out_last, exp_q[0][W-1:0], exp_q[0][W+1:W], exp_q[0][W+2]);
                end
            end
            if (!out_valid) begin
                n_cmp++;
                if (out_last !== 1'b0) begin
                    n_err++;
                    $display("FAIL mon_last_idle t=%0t got=%b exp=0", $time, out_last);
                end
            end
            if (rst) begin
                exp_q.delete();
                sorting = 1'b0;
            end else begin
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    if (out_last) n_last++;
                    void'(exp_q.pop_front());
                end
                sorting = in_valid && in_ready;
                if (in_valid && in_ready) begin
                    n_acc++;
                    for (int k = 0; k < 3; k++) exp_q.push_back(model_elem(a, b, c, 1'b0, k));
                end
            end
        end
    end

    task automatic drive_triple(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        a = x; b = y; c = z; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL drive_timeout got=in_ready_low exp=accept");
        end
    endtask

    task automatic wait_out(output logic [W-1:0] d, output logic [1:0] s, output logic l);
        d = 'x; s = 'x; l = 1'bx;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                d = out_data; s = out_src; l = out_last;
                return;
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && in_ready) return;
        end
        n_cmp++; n_err++;
        $display("FAIL drain_timeout got=%0d exp=0", exp_q.size());
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        a = 8'd1; b = 8'd2; c = 8'd3;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, out_data, out_src, out_last} !== {1'b1, 1'b0, 8'd0, 2'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs got=%b/%b/%h/%0d/%b exp=1/0/00/0/0",
                     in_ready, out_valid, out_data, out_src, out_last);
        end
        n_cmp++;
        if (dbg_state !== 2'd0 || in_ready_d !== 1'b1 || out_valid_d !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state got=%0d/%b/%b exp=0/1/0", dbg_state, in_ready_d, out_valid_d);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] ed[3] = '{8'd10, 8'd20, 8'd30};
        logic [1:0]   es[3] = '{2'd1, 2'd2, 2'd0};
        out_ready = 1'b1;
        drive_triple(8'd30, 8'd10, 8'd20);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_sort_cycle got=%b exp=0", out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, out_data, out_src, out_last} !== {1'b1, ed[k], es[k], (k == 2)}) begin
                n_err++;
                $display("FAIL basic_elem%0d got=%b/%0d/%0d/%b exp=1/%0d/%0d/%b",
                         k, out_valid, out_data, out_src, out_last, ed[k], es[k], k == 2);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL basic_return_idle got=%b/%b exp=1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_ties();
        logic [W-1:0] d;
        logic [1:0]   s;
        logic         l;
        logic [W-1:0] ed[6] = '{8'd7, 8'd7, 8'd7, 8'd3, 8'd3, 8'd9};
        logic [1:0]   es[6] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd0};
        out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) drive_triple(8'd7, 8'd7, 8'd7);
            else        drive_triple(8'd9, 8'd3, 8'd3);
            for (int k = 0; k < 3; k++) begin
                wait_out(d, s, l);
                n_cmp++;
                if ({d, s, l} !== {ed[3*t+k], es[3*t+k], (k == 2)}) begin
                    n_err++;
                    $display("FAIL ties_t%0d_e%0d got=%0d/%0d/%b exp=%0d/%0d/%b",
                             t, k, d, s, l, ed[3*t+k], es[3*t+k], k == 2);
                end
            end
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d;
        logic [1:0]   s;
        logic         l;
        out_ready = 1'b1;
        drive_triple(8'd1, 8'd2, 8'd3);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, out_data, out_src, out_last, in_ready} !== {1'b1, 8'd2, 2'd1, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold%0d got=%b/%0d/%0d/%b/%b exp=1/2/1/0/0",
                         i, out_valid, out_data, out_src, out_last, in_ready);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_out(d, s, l);
        wait_out(d, s, l);
        n_cmp++;
        if ({d, s, l} !== {8'd3, 2'd2, 1'b1}) begin
            n_err++;
            $display("FAIL bp_final got=%0d/%0d/%b exp=3/2/1", d, s, l);
        end
        wait_drain();
    endtask

    task automatic test_extremes();
        logic [W-1:0] d;
        logic [1:0]   s;
        logic         l;
        logic [W-1:0] ea[3] = '{8'h00, 8'h80, 8'hFF};
        logic [W-1:0] xa[6] = '{8'hFF, 8'h00, 8'h80, 8'd5, 8'd5, 8'd9};
        logic [W-1:0] dd[6] = '{8'hFF, 8'h80, 8'h00, 8'd9, 8'd5, 8'd5};
        logic [1:0]   ds[6] = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd0, 2'd1};
        bit           got;
        out_ready = 1'b1;
        drive_triple(8'hFF, 8'h00, 8'h80);
        for (int k = 0; k < 3; k++) begin
            wait_out(d, s, l);
            n_cmp++;
            if (d !== ea[k]) begin
                n_err++;
                $display("FAIL ext_asc_e%0d got=%h exp=%h", k, d, ea[k]);
            end
        end
        wait_drain();
        out_ready_d = 1'b1;
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1;
            a = xa[3*t]; b = xa[3*t+1]; c = xa[3*t+2];
            in_valid_d = 1'b1;
            @(posedge clk); #1;
            in_valid_d = 1'b0;
            for (int k = 0; k < 3; k++) begin
                got = 1'b0;
                for (int i = 0; i < 20 && !got; i++) begin
                    @(negedge clk);
                    got = out_valid_d;
                end
                n_cmp++;
                if ({got, out_data_d, out_src_d, out_last_d} !== {1'b1, dd[3*t+k], ds[3*t+k], (k == 2)}) begin
                    n_err++;
                    $display("FAIL ext_desc_t%0d_e%0d got=%b/%h/%0d/%b exp=1/%h/%0d/%b", t, k,
                             got, out_data_d, out_src_d, out_last_d, dd[3*t+k], ds[3*t+k], k == 2);
                end
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({in_ready_d, out_valid_d} !== 2'b10) begin
            n_err++;
            $display("FAIL ext_desc_idle got=%b/%b exp=1/0", in_ready_d, out_valid_d);
        end
    endtask

    task automatic test_reset_mid_emit();
        logic [W-1:0] d;
        logic [1:0]   s;
        logic         l;
        int           last0;
        logic [W-1:0] ed[3] = '{8'd4, 8'd5, 8'd6};
        logic [1:0]   es[3] = '{2'd0, 2'd2, 2'd1};
        out_ready = 1'b1;
        drive_triple(8'd9, 8'd8, 8'd7);
        last0 = n_last;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready, out_last} !== 3'b010 || n_last != last0) begin
            n_err++;
            $display("FAIL rst_mid_emit got=%b/%b/%b lasts=%0d exp=0/1/0 lasts=%0d",
                     out_valid, in_ready, out_last, n_last, last0);
        end
        drive_triple(8'd4, 8'd6, 8'd5);
        for (int k = 0; k < 3; k++) begin
            wait_out(d, s, l);
            n_cmp++;
            if ({d, s, l} !== {ed[k], es[k], (k == 2)}) begin
                n_err++;
                $display("FAIL rst_new_e%0d got=%0d/%0d/%b exp=%0d/%0d/%b", k, d, s, l, ed[k], es[k], k == 2);
            end
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int  acc0, last0, got;
        bit  took;
        acc0  = n_acc;
        last0 = n_last;
        got   = 0;
        @(posedge clk); #1;
        a = W'($urandom_range(0, 3)); b = W'($urandom_range(0, 3)); c = W'($urandom_range(0, 255));
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 3000 && got < 25; cyc++) begin
            @(negedge clk);
            took = in_ready;
            if (took) got++;
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
            if (took) begin
                if ($urandom_range(0, 1) == 0) begin
                    a = W'($urandom_range(0, 3)); b = W'($urandom_range(0, 3)); c = W'($urandom_range(0, 3));
                end else begin
                    a = W'($urandom_range(0, 255)); b = W'($urandom_range(0, 255)); c = W'($urandom_range(0, 255));
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        n_cmp++;
        if (got != 25 || (n_acc - acc0) != 25) begin
            n_err++;
            $display("FAIL b2b_accepts got=%0d/%0d exp=25", got, n_acc - acc0);
        end
        n_cmp++;
        if ((n_last - last0) != (n_acc - acc0)) begin
            n_err++;
            $display("FAIL b2b_last_count got=%0d exp=%0d", n_last - last0, n_acc - acc0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_backpressure();
        test_extremes();
        test_reset_mid_emit();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
